// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save stream accumulator.
//   csa_state_t   : controller states (ACC, RESOLVE, OUT)
//   DEF_*         : default operand, accumulator and counter widths
package csa_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } csa_state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ACC_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/csa_row.sv
// Combinational W-bit 3:2 compressor (a row of independent full adders).
//   i_a, i_b, i_c : three W-bit addends
//   o_sum         : bitwise sum (XOR of the three inputs)
//   o_carry       : bitwise majority, unshifted; bit k carries weight 2^(k+1)
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Multi-operand accumulator keeping the running total in carry-save form.
// Operands are folded in one per cycle with no carry propagation; the last
// operand of a group triggers a single carry-propagate add, after which the
// result is offered on the output handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear, aborts the group and drops any result
//   in_valid/in_ready/in_data/in_last : operand stream
//   out_valid/out_ready/out_sum/out_ovf/out_count : result stream
//   dbg_state    : current controller state
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its payload stable until accepted;
// ready never depends on valid. out_sum/out_ovf/out_count stay stable while
// out_valid && !out_ready.
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic [CNT_WIDTH-1:0] out_count,
  output csa_state_t           dbg_state
);

  csa_state_t             r_state;
  csa_state_t             w_state_nxt;

  logic [ACC_WIDTH-1:0]   r_s;
  logic [ACC_WIDTH-1:0]   r_c;
  logic                   r_ovf;
  logic [CNT_WIDTH-1:0]   r_cnt;

  logic [ACC_WIDTH-1:0]   r_out_sum;
  logic                   r_out_ovf;
  logic [CNT_WIDTH-1:0]   r_out_count;
  logic                   r_out_valid;

  logic [ACC_WIDTH-1:0]   w_d;
  logic [ACC_WIDTH-1:0]   w_row_s;
  logic [ACC_WIDTH-1:0]   w_row_maj;
  logic [ACC_WIDTH:0]     w_resolve;
  logic                   w_accept;

  // rst_n gates in_ready so nothing is offered as accepted during reset.
  assign in_ready  = rst_n && (r_state == ACC) && !clr;
  assign w_accept  = in_valid && in_ready;
  assign w_d       = ACC_WIDTH'(in_data);
  assign w_resolve = {1'b0, r_s} + {1'b0, r_c};

  csa_row #(.W(ACC_WIDTH)) u_row (
    .i_a     (r_s),
    .i_b     (r_c),
    .i_c     (w_d),
    .o_sum   (w_row_s),
    .o_carry (w_row_maj)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (w_accept && in_last) w_state_nxt = RESOLVE;
      RESOLVE: w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
    if (clr) w_state_nxt = ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_c         <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_s         <= '0;
      r_c         <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_accept) begin
            r_s <= w_row_s;
            // The carry vector is shifted left one place; a majority bit in
            // the top position has weight 2^ACC_WIDTH and is lost from the
            // redundant total, so it marks overflow of the true sum.
            r_c   <= {w_row_maj[ACC_WIDTH-2:0], 1'b0};
            r_ovf <= r_ovf | w_row_maj[ACC_WIDTH-1];
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        RESOLVE: begin
          r_out_sum   <= w_resolve[ACC_WIDTH-1:0];
          r_out_ovf   <= r_ovf | w_resolve[ACC_WIDTH];
          r_out_count <= r_cnt;
          r_out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_c         <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign out_count = r_out_count;
  assign out_valid = r_out_valid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
module tb_csa_stream_accumulator;
  import csa_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic [7:0] out_count;
  csa_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_stream_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b want 1 after %0d cycles", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_valid(output logic got);
    int n;
    got = 1'b0;
    n = 0;
    while (n < 10) begin
      if (out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0; in_last = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_sum !== 8'd0) begin errors++; $display("FAIL reset_out_sum: got %0d want 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    checks++; if (dbg_state !== ACC) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ACC); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(4'd5, 1'b0);
    send(4'd9, 1'b0);
    send(4'd15, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_resolve_ready: got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b want 1", out_valid); end
    checks++; if (out_sum !== 8'd29) begin errors++; $display("FAIL basic_sum: got %0d want 29", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", out_ovf); end
    checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", out_count); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_overflow();
    logic got;
    // 18 x 15 = 270 -> 14 with overflow
    for (int i = 0; i < 18; i++) send(4'd15, i == 17);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL ovf18_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (out_sum !== 8'd14) begin errors++; $display("FAIL ovf18_sum: got %0d want 14", out_sum); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf18_ovf: got %b want 1", out_ovf); end
    checks++; if (out_count !== 8'd18) begin errors++; $display("FAIL ovf18_count: got %0d want 18", out_count); end
    tick();
    // 17 x 15 = 255: largest sum without overflow
    for (int i = 0; i < 17; i++) send(4'd15, i == 16);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL ovf255_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (out_sum !== 8'd255) begin errors++; $display("FAIL ovf255_sum: got %0d want 255", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf255_ovf: got %b want 0", out_ovf); end
    tick();
    // 17 x 15 + 1 = 256: smallest overflowing sum
    for (int i = 0; i < 17; i++) send(4'd15, 1'b0);
    send(4'd1, 1'b1);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL ovf256_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (out_sum !== 8'd0) begin errors++; $display("FAIL ovf256_sum: got %0d want 0", out_sum); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf256_ovf: got %b want 1", out_ovf); end
    checks++; if (out_count !== 8'd18) begin errors++; $display("FAIL ovf256_count: got %0d want 18", out_count); end
    tick();
  endtask

  task automatic test_saturation();
    logic got;
    // 300 ones: sum 300 mod 256 = 44, overflow, count saturates at 255
    for (int i = 0; i < 300; i++) send(4'd1, i == 299);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL sat_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (out_sum !== 8'd44) begin errors++; $display("FAIL sat_sum: got %0d want 44", out_sum); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", out_ovf); end
    checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", out_count); end
    tick();
  endtask

  task automatic test_backpressure();
    logic got;
    out_ready = 1'b0;
    send(4'd3, 1'b0);
    send(4'd4, 1'b1);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL bp_timeout: out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_sum !== 8'd7) begin errors++; $display("FAIL bp_hold_sum[%0d]: got %0d want 7", i, out_sum); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    send(4'd1, 1'b1);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL bp_next_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (out_sum !== 8'd1) begin errors++; $display("FAIL bp_next_sum: got %0d want 1", out_sum); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL bp_next_count: got %0d want 1", out_count); end
    tick();
  endtask

  task automatic test_gaps();
    logic got;
    repeat (3) tick();
    send(4'd7, 1'b1);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (out_sum !== 8'd7) begin errors++; $display("FAIL single_sum: got %0d want 7", out_sum); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d want 1", out_count); end
    tick();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(4'(i + 1), i == 3);
    end
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL gaps_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (out_sum !== 8'd10) begin errors++; $display("FAIL gaps_sum: got %0d want 10", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL gaps_ovf: got %b want 0", out_ovf); end
    checks++; if (out_count !== 8'd4) begin errors++; $display("FAIL gaps_count: got %0d want 4", out_count); end
    tick();
  endtask

  task automatic test_clear();
    logic got;
    send(4'd8, 1'b0);
    send(4'd8, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 4'd5; in_last = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready: got %b want 0", in_ready); end
    tick();
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    send(4'd2, 1'b1);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL clr_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (out_sum !== 8'd2) begin errors++; $display("FAIL clr_sum: got %0d want 2", out_sum); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL clr_count: got %0d want 1", out_count); end
    tick();
    out_ready = 1'b0;
    send(4'd6, 1'b1);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL clr_out_timeout: out_valid=%b want 1", out_valid); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_drop_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_drop_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    send(4'd3, 1'b1);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL clr_after_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (out_sum !== 8'd3) begin errors++; $display("FAIL clr_after_sum: got %0d want 3", out_sum); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL clr_after_count: got %0d want 1", out_count); end
    tick();
  endtask

  task automatic test_async_reset();
    logic got;
    send(4'd6, 1'b0);
    send(4'd9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_sum !== 8'd0) begin errors++; $display("FAIL arst_out_sum: got %0d want 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL arst_out_ovf: got %b want 0", out_ovf); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL arst_out_count: got %0d want 0", out_count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_release_ready: got %b want 1", in_ready); end
    send(4'd6, 1'b1);
    wait_valid(got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL arst_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (out_sum !== 8'd6) begin errors++; $display("FAIL arst_sum: got %0d want 6", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf: got %b want 0", out_ovf); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL arst_count: got %0d want 1", out_count); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_saturation();
    test_backpressure();
    test_gaps();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
